// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, mux selects,
// opcodes and the control bundle produced by the state decoder.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALU_OP_ADD   = 2'd0;
    localparam logic [1:0] ALU_OP_SUB   = 2'd1;
    localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

    localparam logic [1:0] ALUSRCB_B      = 2'd0;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'd1;
    localparam logic [1:0] ALUSRCB_IMM    = 2'd2;
    localparam logic [1:0] ALUSRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        ST_RST      = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC     = 4'd7,
        ST_R_WB     = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_ADDI_EX  = 4'd11,
        ST_ADDI_WB  = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle. MC_CTRL_MEM_WAIT_EN adds the mem_ready handshake.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
`ifdef MC_CTRL_MEM_WAIT_EN
    logic       mem_ready;
`endif
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state_o;

    modport master (
        input  opcode, zero,
`ifdef MC_CTRL_MEM_WAIT_EN
        input  mem_ready,
`endif
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state_o
    );

    modport slave (
        output opcode, zero,
`ifdef MC_CTRL_MEM_WAIT_EN
        output mem_ready,
`endif
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state_o
    );
endinterface

// File: rtl/mips_ctrl_out_decode.sv
// Moore output decode: state -> control bundle. Unused state codes decode to all-zero.
module mips_ctrl_out_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = ALUSRCB_FOUR;
                ctrl.pc_write  = 1'b1;
            end
            ST_DECODE:   ctrl.alu_src_b = ALUSRCB_IMM_SH;
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            ST_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ST_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
            end
            ST_ADDI_WB: ctrl.reg_write = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS controller: state register, next-state logic and opcode latch.
// Define MC_CTRL_MEM_WAIT_EN to stall the memory states on mem_ready.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    mips_multicycle_ctrl_if.master bus
);

    state_t     state, state_nx;
    logic [5:0] op_q;
    ctrl_t      ctrl;
    logic       mem_rdy;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign mem_rdy = bus.mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RST;
            op_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_DECODE) op_q <= bus.opcode;
        end
    end

    always_comb begin
        state_nx = ST_FETCH;
        case (state)
            ST_FETCH:  state_nx = mem_rdy ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_nx = ST_MEM_ADDR;
                    OP_RTYPE:     state_nx = ST_EXEC;
                    OP_BEQ:       state_nx = ST_BRANCH;
                    OP_J:         state_nx = ST_JUMP;
                    OP_ADDI:      state_nx = ST_ADDI_EX;
                    default:      state_nx = ST_FETCH;
                endcase
            end
            // LW/SW split uses the latched opcode so IR changes later are harmless
            ST_MEM_ADDR: state_nx = (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   state_nx = mem_rdy ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WR:   state_nx = mem_rdy ? ST_FETCH : ST_MEM_WR;
            ST_EXEC:     state_nx = ST_R_WB;
            ST_ADDI_EX:  state_nx = ST_ADDI_WB;
            default:     state_nx = ST_FETCH;
        endcase
    end

    mips_ctrl_out_decode u_dec (
        .state (state),
        .ctrl  (ctrl)
    );

    // a stalled fetch must not advance PC or overwrite IR
    assign bus.pc_write      = ctrl.pc_write & ((state != ST_FETCH) | mem_rdy);
    assign bus.ir_write      = ctrl.ir_write & mem_rdy;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.iord          = ctrl.iord;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.illegal_op    = (state == ST_DECODE) && !op_legal(bus.opcode);
    assign bus.state_o       = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-cycle expected state/outputs
// are queued from the state table and compared as the controller steps.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } outs_t;

    typedef struct {
        logic [3:0] st;
        logic [5:0] op;
        logic       rdy;
        outs_t      outs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    mips_multicycle_ctrl_if b();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    always #5 clk = ~clk;

    function automatic outs_t dut_outs();
        outs_t o;
        o.pc_write      = b.pc_write;
        o.pc_write_cond = b.pc_write_cond;
        o.iord          = b.iord;
        o.mem_read      = b.mem_read;
        o.mem_write     = b.mem_write;
        o.ir_write      = b.ir_write;
        o.mem_to_reg    = b.mem_to_reg;
        o.reg_dst       = b.reg_dst;
        o.reg_write     = b.reg_write;
        o.alu_src_a     = b.alu_src_a;
        o.alu_src_b     = b.alu_src_b;
        o.alu_op        = b.alu_op;
        o.pc_source     = b.pc_source;
        o.illegal_op    = b.illegal_op;
        return o;
    endfunction

    function automatic outs_t ref_outs(input logic [3:0] st, input logic [5:0] op, input logic rdy);
        outs_t o = '0;
        case (st)
            4'd1:  begin o.mem_read = 1; o.ir_write = rdy; o.alu_src_b = 1; o.pc_write = rdy; end
            4'd2:  begin
                o.alu_src_b = 3;
                o.illegal_op = !(op == 6'h00 || op == 6'h23 || op == 6'h2B ||
                                 op == 6'h04 || op == 6'h02 || op == 6'h08);
            end
            4'd3:  begin o.alu_src_a = 1; o.alu_src_b = 2; end
            4'd4:  begin o.mem_read = 1; o.iord = 1; end
            4'd5:  begin o.reg_write = 1; o.mem_to_reg = 1; end
            4'd6:  begin o.mem_write = 1; o.iord = 1; end
            4'd7:  begin o.alu_src_a = 1; o.alu_op = 2; end
            4'd8:  begin o.reg_write = 1; o.reg_dst = 1; end
            4'd9:  begin o.alu_src_a = 1; o.alu_op = 1; o.pc_write_cond = 1; o.pc_source = 1; end
            4'd10: begin o.pc_write = 1; o.pc_source = 2; end
            4'd11: begin o.alu_src_a = 1; o.alu_src_b = 2; end
            4'd12: o.reg_write = 1;
            default: ;
        endcase
        return o;
    endfunction

    // Queue the per-cycle expectation for one instruction starting at FETCH.
    // op_after is what the IR shows once DECODE has passed.
    task automatic push_path(input logic [5:0] op, input logic [5:0] op_after);
        logic [3:0] path[$];
        exp_t e;
        case (op)
            6'h23:   path = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
            6'h2B:   path = '{4'd1, 4'd2, 4'd3, 4'd6};
            6'h00:   path = '{4'd1, 4'd2, 4'd7, 4'd8};
            6'h04:   path = '{4'd1, 4'd2, 4'd9};
            6'h02:   path = '{4'd1, 4'd2, 4'd10};
            6'h08:   path = '{4'd1, 4'd2, 4'd11, 4'd12};
            default: path = '{4'd1, 4'd2};
        endcase
        foreach (path[i]) begin
            e.st   = path[i];
            e.op   = (i <= 1) ? op : op_after;
            e.rdy  = 1'b1;
            e.outs = ref_outs(e.st, e.op, 1'b1);
            sb.push_back(e);
        end
    endtask

    // Drive one queued cycle: apply its inputs, let them settle, leave the
    // entry for the caller to compare, then advance by calling next_cycle.
    task automatic apply(input exp_t e);
        b.opcode = e.op;
`ifdef MC_CTRL_MEM_WAIT_EN
        b.mem_ready = e.rdy;
`endif
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        b.opcode = 6'h00;
        b.zero   = 1'b0;
`ifdef MC_CTRL_MEM_WAIT_EN
        b.mem_ready = 1'b1;
`endif
        #2;
        checks++;
        if (b.state_o !== 4'd0 || dut_outs() !== outs_t'(0)) begin
            failures++;
            $display("FAIL reset_hold state=%0d outs=%h want state=0 outs=0", b.state_o, dut_outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (b.state_o !== 4'd0) begin
            failures++;
            $display("FAIL reset_rst_cycle state=%0d want 0", b.state_o);
        end
        next_cycle();
        checks++;
        if (b.state_o !== 4'd1) begin
            failures++;
            $display("FAIL reset_to_fetch state=%0d want 1", b.state_o);
        end
    endtask

    task automatic test_instr(input string name, input logic [5:0] op,
                              input logic [5:0] op_after, input logic z);
        exp_t e;
        b.zero = z;
        push_path(op, op_after);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            apply(e);
            checks++;
            if (b.state_o !== e.st || dut_outs() !== e.outs) begin
                failures++;
                $display("FAIL %s state=%0d outs=%h want state=%0d outs=%h",
                         name, b.state_o, dut_outs(), e.st, e.outs);
            end
            checks++;
            if ((b.mem_read && b.mem_write) || (b.reg_write && (b.pc_write || b.pc_write_cond))) begin
                failures++;
                $display("FAIL %s_exclusive state=%0d outs=%h want no overlap", name, b.state_o, dut_outs());
            end
            next_cycle();
        end
        checks++;
        if (b.state_o !== 4'd1) begin
            failures++;
            $display("FAIL %s_return state=%0d want 1", name, b.state_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[$] = '{6'h08, 6'h23, 6'h00, 6'h04, 6'h2B, 6'h02, 6'h11};
        foreach (ops[i]) test_instr("b2b", ops[i], ops[(i + 1) % ops.size()], i[0]);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        push_path(6'h23, 6'h23);
        repeat (4) begin
            e = sb.pop_front();
            apply(e);
            checks++;
            if (b.state_o !== e.st || dut_outs() !== e.outs) begin
                failures++;
                $display("FAIL rst_mid_pre state=%0d outs=%h want state=%0d outs=%h",
                         b.state_o, dut_outs(), e.st, e.outs);
            end
            if (e.st != 4'd4) next_cycle();
        end
        sb.delete();
        rst_n = 1'b0;
        #1;
        checks++;
        if (b.state_o !== 4'd0 || dut_outs() !== outs_t'(0)) begin
            failures++;
            $display("FAIL rst_mid_async state=%0d outs=%h want state=0 outs=0", b.state_o, dut_outs());
        end
        @(posedge clk);
        #1;
        checks++;
        if (b.state_o !== 4'd0 || b.reg_write !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_held state=%0d reg_write=%b want state=0 reg_write=0", b.state_o, b.reg_write);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (b.state_o !== 4'd0) begin
            failures++;
            $display("FAIL rst_mid_rst_cycle state=%0d want 0", b.state_o);
        end
        next_cycle();
        checks++;
        if (b.state_o !== 4'd1) begin
            failures++;
            $display("FAIL rst_mid_fetch state=%0d want 1", b.state_o);
        end
    endtask

`ifdef MC_CTRL_MEM_WAIT_EN
    task automatic test_mem_wait();
        exp_t e;
        int   irw = 0;
        int   pcw = 0;
        repeat (3) begin
            e.st = 4'd1; e.op = 6'h23; e.rdy = 1'b0;
            e.outs = ref_outs(4'd1, 6'h23, 1'b0);
            sb.push_back(e);
        end
        push_path(6'h23, 6'h23);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            apply(e);
            if (b.state_o == 4'd1) begin
                irw += int'(b.ir_write);
                pcw += int'(b.pc_write);
            end
            checks++;
            if (b.state_o !== e.st || dut_outs() !== e.outs) begin
                failures++;
                $display("FAIL mem_wait state=%0d outs=%h want state=%0d outs=%h",
                         b.state_o, dut_outs(), e.st, e.outs);
            end
            next_cycle();
        end
        b.mem_ready = 1'b1;
        checks++;
        if (irw != 1 || pcw != 1) begin
            failures++;
            $display("FAIL mem_wait_pulses ir_write=%0d pc_write=%0d want 1 1", irw, pcw);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_instr("lw", 6'h23, 6'h23, 1'b0);
        test_instr("sw_latch", 6'h2B, 6'h23, 1'b0);
        test_instr("rtype", 6'h00, 6'h00, 1'b0);
        test_instr("beq", 6'h04, 6'h04, 1'b1);
        test_instr("jump", 6'h02, 6'h02, 1'b0);
        test_instr("addi", 6'h08, 6'h08, 1'b0);
        test_instr("illegal", 6'h3F, 6'h3F, 1'b0);
        test_back_to_back();
        test_reset_mid();
`ifdef MC_CTRL_MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout state=%0d", b.state_o);
        $fatal(1, "timeout");
    end

endmodule
